// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand loader:
//   - state_e       : loader FSM states (opcode, operand A, operand B, issue)
//   - ERR_OVERRUN   : err bit set when a byte arrives while a set is pending
//   - ERR_TIMEOUT   : err bit set when a partial load is abandoned for idling
//   - DEF_*         : default widths / timeout used by the loader parameters
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        S_OPC   = 2'd0,
        S_A     = 2'd1,
        S_B     = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_TIMEOUT = 1;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_OPC_W       = 3;
    localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/pin_edge_sync.sv
// ---------------------------------------------------------------------------
// pin_edge_sync
// Brings an asynchronous pin strobe into the clk domain through a 2-flop
// synchronizer and produces a one-cycle pulse on each synchronized rising
// edge. A pin that is already high when reset is released does not produce
// a pulse; it must be seen low first.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   pin_i  : asynchronous strobe
//   rise_o : one-cycle pulse, high in the cycle after the edge is synchronized
// ---------------------------------------------------------------------------
module pin_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic rise_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[0], 1'b1};
            // sync_q only reflects the real pin once the pipeline has been
            // refilled after reset; arm only after a genuine low is observed.
            if (fill_q[1] && !sync_q)
                armed_q <= 1'b1;
        end
    end

    assign rise_o = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
// Collects an opcode byte and two operand bytes delivered one per rising
// edge of the asynchronous load pin, then presents them to the ALU with a
// valid/ready handshake. Bytes arriving while a set is pending are dropped
// and flagged (err[0]). Optional build macro LOADER_TIMEOUT_EN abandons a
// partial load after TIMEOUT_CYC idle cycles and flags err[1].
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ena             : block select; low freezes the FSM and drops edges
//   data_in         : byte bus (must be stable from load rise to capture)
//   load            : asynchronous byte strobe
//   op_ready        : ALU accepts the presented operand set
//   op_valid        : operand set presented
//   opcode,op_a,op_b: operand set
//   busy            : a load or issue is in progress
//   err             : sticky flags, bit0 overrun, bit1 timeout
// ---------------------------------------------------------------------------
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OPC_W       = DEF_OPC_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              op_ready,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OPC_W-1:0]  opcode,
    output logic              busy,
    output logic [1:0]        err
);

    state_e              state_q, state_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [1:0]          err_q, err_d;
    logic                rise;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    pin_edge_sync u_load_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (load),
        .rise_o (rise)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        err_d    = err_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        if (ena) begin
            case (state_q)
                S_OPC: begin
                    if (rise) begin
                        opcode_d = data_in[OPC_W-1:0];
                        state_d  = S_A;
                    end
                end
                S_A: begin
                    if (rise) begin
                        op_a_d  = data_in;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (rise) begin
                        op_b_d  = data_in;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The byte is always dropped, even if the handshake
                    // completes on the same edge.
                    if (rise)
                        err_d[ERR_OVERRUN] = 1'b1;
                    if (op_ready)
                        state_d = S_OPC;
                end
                default: state_d = S_OPC;
            endcase

`ifdef LOADER_TIMEOUT_EN
            // Idle cycles are only counted while a partial set is pending.
            if (state_q == S_A || state_q == S_B) begin
                if (rise) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d                = '0;
                    state_d              = S_OPC;
                    err_d[ERR_TIMEOUT]   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end else begin
                tmo_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OPC;
            opcode_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            err_q    <= err_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`endif

    assign op_valid = (state_q == S_ISSUE);
    assign busy     = (state_q != S_OPC);
    assign opcode   = opcode_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

    localparam int DATA_W      = 8;
    localparam int OPC_W       = 3;
    localparam int TIMEOUT_CYC = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              op_ready;
    logic              op_valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [OPC_W-1:0]  opcode;
    logic              busy;
    logic [1:0]        err;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .DATA_W      (DATA_W),
        .OPC_W       (OPC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_in  (data_in),
        .load     (load),
        .op_ready (op_ready),
        .op_valid (op_valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .opcode   (opcode),
        .busy     (busy),
        .err      (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the operand set the ALU should currently be offered,
    // the sticky error flags, and per-issue observation counters.
    logic [OPC_W-1:0]  exp_opc = '0;
    logic [DATA_W-1:0] exp_a   = '0;
    logic [DATA_W-1:0] exp_b   = '0;
    logic [1:0]        exp_err = '0;
    int vld_cycles = 0;
    int bad_ops    = 0;

    always @(negedge clk) begin
        if (op_valid === 1'b1) begin
            vld_cycles++;
            if (opcode !== exp_opc || op_a !== exp_a || op_b !== exp_b)
                bad_ops++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap();
        load = 1'b0;
        tick(3 + $urandom_range(0, 3));
    endtask

    // One byte: load held high across the three capture edges.
    task automatic pulse(input logic [DATA_W-1:0] b);
        data_in = b;
        load    = 1'b1;
        tick(3);
        load    = 1'b0;
    endtask

    task automatic load_set(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                            input logic [DATA_W-1:0] b2);
        gap();
        pulse(b0);
        chk("busy_after_opc", busy, 1);
        gap();
        pulse(b1);
        gap();
        exp_opc    = b0[OPC_W-1:0];
        exp_a      = b1;
        exp_b      = b2;
        vld_cycles = 0;
        bad_ops    = 0;
        chk("no_valid_partial", op_valid, 0);
        pulse(b2);
        chk("valid_rise", op_valid, 1);
        chk("opcode", opcode, exp_opc);
        chk("op_a", op_a, exp_a);
        chk("op_b", op_b, exp_b);
    endtask

    task automatic hshake(input int d);
        op_ready = 1'b0;
        tick(d);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("valid_fall", op_valid, 0);
        chk("busy_idle", busy, 0);
        chk("valid_cycles", vld_cycles, d + 1);
        chk("ops_stable", bad_ops, 0);
        chk("err", err, exp_err);
    endtask

    task automatic run_set(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                           input logic [DATA_W-1:0] b2, input int d);
        load_set(b0, b1, b2);
        hshake(d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, op_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] r0, r1, r2;
        logic [OPC_W-1:0]  held_opc;

        rst = 1'b1; ena = 1'b1; load = 1'b0; op_ready = 1'b0; data_in = '0;
        #2;
        chk_all_zero("reset");
        tick(2);
        rst = 1'b0;
        tick(4);

        // Basic issue with the ALU always ready: valid for one cycle.
        op_ready = 1'b1;
        gap(); pulse(8'h02); gap(); pulse(8'h5A); gap();
        exp_opc = 3'd2; exp_a = 8'h5A; exp_b = 8'h33;
        vld_cycles = 0; bad_ops = 0;
        pulse(8'h33);
        chk("t35_valid", op_valid, 1);
        chk("t35_opcode", opcode, 3'd2);
        chk("t35_op_a", op_a, 8'h5A);
        chk("t35_op_b", op_b, 8'h33);
        tick(1);
        op_ready = 1'b0;
        chk("t35_valid_fall", op_valid, 0);
        chk("t35_cycles", vld_cycles, 1);
        chk("t35_err", err, 0);

        // ALU stalls for 10 cycles.
        run_set(8'h07, 8'hA5, 8'h3C, 10);

        // Overrun during issue: byte dropped, handshake still completes.
        load_set(8'h01, 8'h11, 8'h22);
        gap();
        pulse(8'hFF);
        exp_err[0] = 1'b1;
        chk("t37_op_b", op_b, 8'h22);
        chk("t37_err", err, exp_err);
        chk("t37_valid_held", op_valid, 1);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("t37_valid_fall", op_valid, 0);
        chk("t37_ops_stable", bad_ops, 0);

        // Overrun byte captured on the same edge as the handshake.
        load_set(8'h03, 8'h44, 8'h55);
        gap();
        data_in = 8'hEE;
        load    = 1'b1;
        tick(2);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        load     = 1'b0;
        chk("t22_valid", op_valid, 0);
        chk("t22_busy", busy, 0);
        chk("t22_err", err, exp_err);
        chk("t22_op_b", op_b, 8'h55);
        run_set(8'h06, 8'h12, 8'h34, 0);

        // Disabled block ignores loads.
        held_opc = exp_opc;
        ena = 1'b0;
        repeat (3) begin
            gap();
            pulse(8'h05);
        end
        chk("t40_busy", busy, 0);
        chk("t40_valid", op_valid, 0);
        chk("t40_opcode", opcode, held_opc);
        ena = 1'b1;
        run_set(8'h04, 8'h81, 8'h18, 2);

        // Reset while waiting for operand B.
        gap(); pulse(8'h02); gap(); pulse(8'h77);
        chk("t39_pre_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("t39");
        exp_err = '0;
        tick(1);
        rst = 1'b0;
        tick(4);
        run_set(8'h05, 8'h99, 8'h66, 1);

        // Load already high when reset is released.
        rst  = 1'b1;
        load = 1'b1;
        data_in = 8'h03;
        tick(1);
        rst = 1'b0;
        tick(10);
        chk("t28_busy", busy, 0);
        chk("t28_opcode", opcode, 0);
        load = 1'b0;
        tick(3);
        run_set(8'h03, 8'h21, 8'h43, 0);

        // Silence after two bytes.
        gap(); pulse(8'h02); gap(); pulse(8'h10);
`ifdef LOADER_TIMEOUT_EN
        tick(TIMEOUT_CYC - 1);
        chk("t38_busy_before", busy, 1);
        tick(1);
        exp_err[1] = 1'b1;
        chk("t38_busy_after", busy, 0);
        chk("t38_err", err, exp_err);
        chk("t38_valid", op_valid, 0);
        run_set(8'h01, 8'h02, 8'h03, 0);
`else
        tick(TIMEOUT_CYC + 1);
        chk("t38_busy_held", busy, 1);
        chk("t38_valid", op_valid, 0);
        chk("t38_err", err, exp_err);
        exp_opc = 3'd2; exp_a = 8'h10; exp_b = 8'hC3;
        vld_cycles = 0; bad_ops = 0;
        pulse(8'hC3);
        chk("t38_valid_issue", op_valid, 1);
        chk("t38_op_a", op_a, 8'h10);
        chk("t38_op_b", op_b, 8'hC3);
        hshake(0);
`endif

        // Randomized operand sets and ALU stall lengths.
        for (int i = 0; i < 20; i++) begin
            r0 = DATA_W'($urandom);
            r1 = DATA_W'($urandom);
            r2 = DATA_W'($urandom);
            run_set(r0, r1, r2, $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand and data-bus width.
REQ-002 SHALL have parameter OPC_W, default 3, opcode width taken from the opcode byte bits [OPC_W-1:0].
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of idle cycles allowed between bytes of one partial load.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1, the asynchronous, active-high reset.
REQ-006 SHALL have port ena, input, 1; when it is high the design is selected.
REQ-007 SHALL have port data_in, input, DATA_W, the byte bus driven from the dedicated input pins.
REQ-008 SHALL have port load, input, 1, the asynchronous pin strobe; each rising edge delivers one byte.
REQ-009 SHALL have port op_ready, input, 1, the ALU-side accept signal.
REQ-010 SHALL have port op_valid, output, 1, meaning the operand set is presented.
REQ-011 SHALL have ports op_a and op_b, output, DATA_W each, and opcode, output, OPC_W, which together form the operand set for the downstream ALU.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not S_OPC.
REQ-013 SHALL have port err, output, 2, sticky flags: bit0 overrun, bit1 timeout.

Function
REQ-014 SHALL pass load through a 2-flop synchronizer followed by a registered rising-edge detector; a byte is captured on the third clk edge at which load is sampled high.
REQ-015 SHALL require data_in to be stable from the load rise through the capture edge; data_in is not synchronized.
REQ-016 SHALL implement the states S_OPC, S_A, S_B and S_ISSUE.
REQ-017 SHALL, on a detected edge in S_OPC: opcode<=data_in[OPC_W-1:0], next state S_A.
REQ-018 SHALL, on a detected edge in S_A: op_a<=data_in, next state S_B.
REQ-019 SHALL, on a detected edge in S_B: op_b<=data_in, next state S_ISSUE, with op_valid high from the following cycle.
REQ-020 SHALL, in S_ISSUE, hold op_valid and all operands stable until op_valid&&op_ready is sampled, then return to S_OPC with op_valid low on the next cycle.
REQ-021 SHALL, on a detected edge in S_ISSUE, discard the byte, leave the operands unchanged and set err[0].
REQ-022 SHALL, when op_ready is high on the same edge as a detected edge in S_ISSUE, complete the handshake, still discard the byte and set err[0].
REQ-023 SHALL, while ena is low, freeze the FSM and discard detected edges; the synchronizer keeps running.
REQ-024 SHALL never assert op_valid for an incomplete set.
REQ-025 SHALL keep err sticky until reset.

Reset
REQ-026 SHALL, on rst high, immediately force: state S_OPC; op_valid, busy, opcode, op_a, op_b and err to 0; synchronizer and edge flops to 0; timeout counter to 0.
REQ-027 SHALL, when rst is asserted mid-sequence or during S_ISSUE, abandon the partial set without any handshake.
REQ-028 SHALL, when load is already high at reset release, not produce a capture until load falls and rises again.

Configuration
REQ-029 SHALL, when LOADER_TIMEOUT_EN is defined, count consecutive cycles in S_A or S_B with no detected edge; the counter clears on each detected edge.
REQ-030 SHALL, when the count reaches TIMEOUT_CYC, return to S_OPC on that edge and set err[1].
REQ-031 SHALL, when LOADER_TIMEOUT_EN is undefined, remove the counter, keep err[1] at constant 0, and never time out a partial load.
REQ-032 SHALL NOT apply the timeout in S_ISSUE in either build.

Structure
REQ-033 SHALL place the state enum, the err bit indices (ERR_OVERRUN=0, ERR_TIMEOUT=1) and the default widths in the shared package alu_pkg.
REQ-034 SHALL use one sub-module, pin_edge_sync (2-flop synchronizer plus rising-edge pulse), reusable for other pin strobes.

Verification
REQ-035 SHALL cover: bytes 0x02, 0x5A, 0x33 with op_ready=1 -> op_valid for exactly 1 cycle with opcode=2, op_a=0x5A, op_b=0x33; err=0.
REQ-036 SHALL cover: a full set with op_ready=0 for 10 cycles, then 1 -> op_valid held 11 cycles with operands stable, then S_OPC.
REQ-037 SHALL cover: a fourth load during S_ISSUE with data 0xFF -> op_b unchanged, err=01, handshake still completes.
REQ-038 SHALL cover: two bytes then silence for 256 cycles, TIMEOUT_CYC=255, macro defined -> busy falls, err=10; with the macro undefined, the state is still S_B.
REQ-039 SHALL cover: rst pulse while in S_B -> all outputs 0 at once; a subsequent load treats its byte as the opcode.
REQ-040 SHALL cover: ena=0 while 3 loads are pulsed -> no state change; after ena=1, the next 3 loads produce a normal issue.
